// File: rtl/audio_sample_serializer_pkg.sv
// Shared types and constants for the audio output serializer.
package audio_sample_serializer_pkg;

  localparam int SAMPLE_W = 16;

  // Encodings are shared with FIR_filter and the benches, so keep them fixed.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

endpackage

// File: rtl/audio_sample_serializer_if.sv
// Sample stream handshake from FIR_filter into the serializer.
interface audio_sample_serializer_if
  import audio_sample_serializer_pkg::*;
#(
  parameter int DATA_W = SAMPLE_W
);
  logic [DATA_W-1:0] sample_in;
  logic              sample_valid;
  logic              sample_ready;

  modport master (output sample_in, output sample_valid, input  sample_ready);
  modport slave  (input  sample_in, input  sample_valid, output sample_ready);
endinterface

// File: rtl/audio_sample_serializer_sync_fifo.sv
// Small synchronous FIFO; count is kept apart from the pointers so full/empty never alias.
module audio_sample_serializer_sync_fifo #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push, w_pop;

  // Guard both ends so a stray push when full or pop when empty is harmless.
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Storage write; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // Pointers wrap naturally (DEPTH is a power of 2); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/audio_sample_serializer.sv
// Buffers filtered samples and shifts them out MSB-first on sclk/fsync/sdata.
module audio_sample_serializer
  import audio_sample_serializer_pkg::*;
#(
  parameter  int DATA_W     = SAMPLE_W,
  parameter  int FIFO_DEPTH = 4,
  parameter  int CLK_DIV    = 4,
  localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  audio_sample_serializer_if.slave  s_if,
  input  logic                      i_enable,
  output logic                      o_sclk,
  output logic                      o_fsync,
  output logic                      o_sdata,
  output logic                      o_busy,
  output logic [CW-1:0]             o_fifo_count
);
  localparam int DIV_W = (2 * CLK_DIV > 1) ? $clog2(2 * CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_W);

  state_e            r_state, w_next;
  logic [DIV_W-1:0]  r_div_cnt;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_head;
  logic              w_full, w_empty, w_push, w_pop;
  logic              w_bit_end, w_last_bit, w_more, w_reload;

  assign s_if.sample_ready = !w_full;
  assign w_push     = s_if.sample_valid && !w_full;
  assign w_bit_end  = (r_div_cnt == DIV_W'(2 * CLK_DIV - 1));
  assign w_last_bit = (r_bit_cnt == '0);
  assign w_more     = i_enable && !w_empty;
  // Back-to-back: the next word is popped on the last cycle of bit 0.
  assign w_reload   = (r_state == ST_SHIFT) && w_bit_end && w_last_bit && w_more;
  assign w_pop      = (r_state == ST_LOAD) || w_reload;

  audio_sample_serializer_sync_fifo #(.WIDTH(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (s_if.sample_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fifo_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next state: a frame starts only with enable and data; it always runs to completion.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_more) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_SHIFT;
      ST_SHIFT: if (w_bit_end && w_last_bit && !w_more) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Clock divider, bit counter and shift register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          r_shift   <= w_head;
          r_bit_cnt <= BIT_W'(DATA_W - 1);
          r_div_cnt <= '0;
        end
        ST_SHIFT: begin
          if (w_bit_end) begin
            r_div_cnt <= '0;
            if (w_reload) begin
              r_shift   <= w_head;
              r_bit_cnt <= BIT_W'(DATA_W - 1);
            end else begin
              r_shift   <= {r_shift[DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - 1'b1;
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: r_div_cnt <= '0;
      endcase
    end
  end

  // Outputs: sclk low for the first half of each bit, so sdata moves on the falling edge.
  always_comb begin
    o_busy  = (r_state != ST_IDLE);
    o_sclk  = 1'b0;
    o_fsync = 1'b0;
    o_sdata = 1'b0;
    if (r_state == ST_SHIFT) begin
      o_sclk  = (r_div_cnt >= DIV_W'(CLK_DIV));
      o_fsync = (r_bit_cnt == BIT_W'(DATA_W - 1));
      o_sdata = r_shift[DATA_W-1];
    end
  end
endmodule

// File: tb/tb_audio_sample_serializer.sv
// Directed bench for audio_sample_serializer (DATA_W=16, FIFO_DEPTH=4, CLK_DIV=2).
module tb_audio_sample_serializer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        sclk, fsync, sdata, busy;
  logic [2:0]  fifo_count;
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  audio_sample_serializer_if #(.DATA_W(16)) sif();

  audio_sample_serializer #(.DATA_W(16), .FIFO_DEPTH(4), .CLK_DIV(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_if         (sif),
    .i_enable     (enable),
    .o_sclk       (sclk),
    .o_fsync      (fsync),
    .o_sdata      (sdata),
    .o_busy       (busy),
    .o_fifo_count (fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Called on a negedge; sample is taken at the following posedge.
  task automatic push(input logic [15:0] d);
    chk("push_rdy", 32'(sif.sample_ready), 1);
    sif.sample_valid = 1'b1;
    sif.sample_in    = d;
    exp_q.push_back(d);
    @(negedge clk);
    sif.sample_valid = 1'b0;
  endtask

  task automatic drain(input int lim);
    int k = 0;
    while ((exp_q.size() != 0 || busy) && k < lim) begin
      @(negedge clk);
      k++;
    end
    chk("drain_q", exp_q.size(), 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  // Scoreboard: rebuild words from sdata at each sclk rise and compare to pushed order.
  logic        prev_sclk = 1'b0;
  int          mon_idx = 0;
  logic [15:0] mon_word = '0;
  always @(negedge clk) begin
    if (reset) begin
      mon_idx = 0;
    end else if (sclk && !prev_sclk) begin
      chk("fsync_pos", 32'(fsync), 32'(mon_idx == 0));
      mon_word = {mon_word[14:0], sdata};
      mon_idx++;
      if (mon_idx == 16) begin
        mon_idx = 0;
        if (exp_q.size() == 0) chk("sb_extra", exp_q.size(), 1);
        else                   chk("sb_word", mon_word, exp_q.pop_front());
      end
    end
    prev_sclk = sclk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] w;
    logic [3:0]  ev;
    int          k;
    sif.sample_in    = 16'h1234;
    sif.sample_valid = 1'b1;

    // 1: reset held with valid high; nothing accepted
    repeat (5) begin
      @(negedge clk);
      chk("rst_cnt", 32'(fifo_count), 0);
    end
    chk("rst_outs", 32'({sclk, fsync, sdata, busy, sif.sample_ready}), 32'b00001);
    sif.sample_valid = 1'b0;
    reset  = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    chk("rst_rel_cnt", 32'(fifo_count), 0);

    // 2: single frame, exact waveform
    w = 16'hA5C3;
    push(w);
    @(negedge clk);
    chk("t2_load", 32'({busy, fsync, sclk}), 32'b100);
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      ev[3] = 1'b1;
      ev[2] = (i < 4);
      ev[1] = ((i % 4) >= 2);
      ev[0] = w[15 - i / 4];
      chk("t2_bit", 32'({busy, fsync, sclk, sdata}), 32'(ev));
    end
    @(negedge clk);
    chk("t2_idle", 32'({busy, sclk, fsync, sdata}), 0);
    chk("t2_cnt", 32'(fifo_count), 0);

    // 3: two back-to-back frames with no gap
    push(16'h8001);
    push(16'h7FFE);
    @(negedge clk);
    for (int i = 0; i < 128; i++) begin
      ev = {2'b00, 1'b1, ((i % 64) < 4)};
      chk("t3_frm", 32'({busy, fsync}), 32'(ev));
      @(negedge clk);
    end
    chk("t3_end", 32'(busy), 0);
    drain(50);

    // 4: valid held high from IDLE fills the FIFO
    sif.sample_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("t4_rdy", 32'(sif.sample_ready), 1);
      sif.sample_in = 16'h1100 + 16'(i);
      exp_q.push_back(sif.sample_in);
      @(negedge clk);
    end
    chk("t4_cnt", 32'(fifo_count), 4);
    chk("t4_full", 32'(sif.sample_ready), 0);
    sif.sample_in = 16'hDEAD;
    repeat (10) begin
      @(negedge clk);
      chk("t4_hold", 32'({sif.sample_ready, fifo_count}), 32'b0100);
    end
    sif.sample_valid = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sif.sample_ready && k < 200);
    chk("t4_pop_cyc", k, 52);
    chk("t4_cnt3", 32'(fifo_count), 3);
    drain(600);

    // 5: reset during bit 7 with three samples buffered
    enable = 1'b0;
    for (int i = 0; i < 4; i++) push(16'h5A00 + 16'(i));
    chk("t5_cnt4", 32'(fifo_count), 4);
    enable = 1'b1;
    @(negedge clk);
    chk("t5_load", 32'(busy), 1);
    @(negedge clk);
    repeat (33) @(negedge clk);
    chk("t5_cnt3", 32'(fifo_count), 3);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    chk("t5_rst", 32'({sclk, fsync, sdata, busy, sif.sample_ready}), 32'b00001);
    chk("t5_rst_cnt", 32'(fifo_count), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (150) begin
      @(negedge clk);
      chk("t5_quiet", 32'({busy, fifo_count}), 0);
    end

    // 6: enable dropped mid-frame; buffered sample kept until re-enable
    push(16'h3C96);
    push(16'h0F0F);
    repeat (30) @(negedge clk);
    enable = 1'b0;
    chk("t6_cnt1", 32'(fifo_count), 1);
    k = 0;
    while (busy && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("t6_done", 32'({busy, fifo_count}), 32'b0001);
    repeat (5) begin
      @(negedge clk);
      chk("t6_idle", 32'({busy, fifo_count}), 32'b0001);
    end
    enable = 1'b1;
    @(negedge clk);
    chk("t6_load", 32'({busy, fsync}), 32'b10);
    @(negedge clk);
    chk("t6_fsync", 32'({busy, fsync, sdata}), 32'b110);
    drain(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
